id_ex_pipe: RTL and testbench

// - Parametrised ID->EX pipeline stage: elastic valid/ready register carrying decoded op,

---
 rtl/id_ex_pipe_pkg.sv | 28 ++
 rtl/id_ex_pipe_slot.sv | 61 ++++++
 rtl/id_ex_pipe.sv | 161 ++++++++++++++++
 tb/tb_id_ex_pipe.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_pipe_pkg.sv
// ============================================================================
// id_ex_pipe_pkg : bus widths, NOP encodings and occupancy states for ID->EX
// Revision : 1.0
// ============================================================================
`default_nettype none

package id_ex_pipe_pkg;

   localparam int ALU_SEL_BUS_W  = 3;
   localparam int ALU_OP_BUS_W   = 8;
   localparam int REG_BUS_W      = 32;
   localparam int REG_ADDR_BUS_W = 5;

   localparam logic [ALU_SEL_BUS_W-1:0]  EXE_RES_NOP = 3'b000;
   localparam logic [ALU_OP_BUS_W-1:0]   EXE_NOP_OP  = 8'b0000_0000;
   localparam logic [REG_BUS_W-1:0]      ZeroWord    = 32'h0000_0000;
   localparam logic [REG_ADDR_BUS_W-1:0] NOPRegAddr  = 5'b00000;

   // Encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } pipe_state_t;

endpackage

`default_nettype wire

// File: rtl/id_ex_pipe_slot.sv
// ============================================================================
// pipe_slot : one ID->EX payload register, load enable, sync clear-to-NOP
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_slot
   import id_ex_pipe_pkg::*;
#(
   parameter int DATA_W   = REG_BUS_W,
   parameter int ADDR_W   = REG_ADDR_BUS_W,
   parameter int ALUOP_W  = ALU_OP_BUS_W,
   parameter int ALUSEL_W = ALU_SEL_BUS_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                load,
   input  logic [ALUSEL_W-1:0] new_alusel,
   input  logic [ALUOP_W-1:0]  new_aluop,
   input  logic [DATA_W-1:0]   new_reg1_data,
   input  logic [DATA_W-1:0]   new_reg2_data,
   input  logic [ADDR_W-1:0]   new_waddr,
   input  logic                new_reg_we,
   input  logic                new_in_delay,
   input  logic [DATA_W-1:0]   new_link_addr,
   output logic [ALUSEL_W-1:0] alusel,
   output logic [ALUOP_W-1:0]  aluop,
   output logic [DATA_W-1:0]   reg1_data,
   output logic [DATA_W-1:0]   reg2_data,
   output logic [ADDR_W-1:0]   waddr,
   output logic                reg_we,
   output logic                in_delay,
   output logic [DATA_W-1:0]   link_addr
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         alusel    <= ALUSEL_W'(EXE_RES_NOP);
         aluop     <= ALUOP_W'(EXE_NOP_OP);
         reg1_data <= DATA_W'(ZeroWord);
         reg2_data <= DATA_W'(ZeroWord);
         waddr     <= ADDR_W'(NOPRegAddr);
         reg_we    <= 1'b0;
         in_delay  <= 1'b0;
         link_addr <= DATA_W'(ZeroWord);
      end else if (load) begin
         alusel    <= new_alusel;
         aluop     <= new_aluop;
         reg1_data <= new_reg1_data;
         reg2_data <= new_reg2_data;
         waddr     <= new_waddr;
         reg_we    <= new_reg_we;
         in_delay  <= new_in_delay;
         link_addr <= new_link_addr;
      end
   end

endmodule

`default_nettype wire

// File: rtl/id_ex_pipe.sv
// ============================================================================
// id_ex_pipe : elastic ID->EX stage, optional 2-entry skid, flush to bubble
// Revision : 1.0
// ============================================================================
`default_nettype none

module id_ex_pipe
   import id_ex_pipe_pkg::*;
#(
   parameter int DATA_W   = REG_BUS_W,
   parameter int ADDR_W   = REG_ADDR_BUS_W,
   parameter int ALUOP_W  = ALU_OP_BUS_W,
   parameter int ALUSEL_W = ALU_SEL_BUS_W,
   parameter int SKID_EN  = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                id_valid,
   output logic                id_ready,
   input  logic [ALUSEL_W-1:0] id_alusel,
   input  logic [ALUOP_W-1:0]  id_aluop,
   input  logic [DATA_W-1:0]   id_reg1_data,
   input  logic [DATA_W-1:0]   id_reg2_data,
   input  logic [ADDR_W-1:0]   id_waddr,
   input  logic                id_reg_we,
   input  logic                id_in_delay,
   input  logic [DATA_W-1:0]   id_link_addr,
   output logic                ex_valid,
   input  logic                ex_ready,
   output logic [ALUSEL_W-1:0] ex_alusel,
   output logic [ALUOP_W-1:0]  ex_aluop,
   output logic [DATA_W-1:0]   ex_reg1_data,
   output logic [DATA_W-1:0]   ex_reg2_data,
   output logic [ADDR_W-1:0]   ex_waddr,
   output logic                ex_reg_we,
   output logic                ex_in_delay,
   output logic [DATA_W-1:0]   ex_link_addr,
   output logic [1:0]          occupancy
);

   pipe_state_t state;
   logic        accept;
   logic        consume;
   logic        main_load;
   logic        main_clr;
   logic        sel_skid;

   logic [ALUSEL_W-1:0] main_alusel,    skid_alusel,    new_alusel;
   logic [ALUOP_W-1:0]  main_aluop,     skid_aluop,     new_aluop;
   logic [DATA_W-1:0]   main_reg1_data, skid_reg1_data, new_reg1_data;
   logic [DATA_W-1:0]   main_reg2_data, skid_reg2_data, new_reg2_data;
   logic [ADDR_W-1:0]   main_waddr,     skid_waddr,     new_waddr;
   logic                main_reg_we,    skid_reg_we,    new_reg_we;
   logic                main_in_delay,  skid_in_delay,  new_in_delay;
   logic [DATA_W-1:0]   main_link_addr, skid_link_addr, new_link_addr;

   assign ex_valid  = (state != ST_EMPTY);
   assign occupancy = state;
   assign consume   = ex_valid & ex_ready;
   assign accept    = id_valid & id_ready & ~flush;

   generate
      if (SKID_EN != 0) begin : g_ready_reg
         assign id_ready = (state != ST_FULL);
      end else begin : g_ready_comb
         assign id_ready = ~ex_valid | ex_ready;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state <= ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: if (accept) state <= ST_ONE;
            ST_ONE: begin
               if (accept && !consume && SKID_EN != 0) state <= ST_FULL;
               else if (consume && !accept)            state <= ST_EMPTY;
            end
            ST_FULL:  if (consume) state <= ST_ONE;
            default:  state <= ST_EMPTY;
         endcase
      end
   end

   // Main refills from the skid when draining FULL, otherwise straight from ID.
   assign sel_skid  = (state == ST_FULL);
   assign main_load = (accept & ((state == ST_EMPTY) | ((state == ST_ONE) & consume)))
                    | (sel_skid & consume);
   assign main_clr  = flush | ((state == ST_ONE) & consume & ~accept);

   assign new_alusel    = sel_skid ? skid_alusel    : id_alusel;
   assign new_aluop     = sel_skid ? skid_aluop     : id_aluop;
   assign new_reg1_data = sel_skid ? skid_reg1_data : id_reg1_data;
   assign new_reg2_data = sel_skid ? skid_reg2_data : id_reg2_data;
   assign new_waddr     = sel_skid ? skid_waddr     : id_waddr;
   assign new_reg_we    = sel_skid ? skid_reg_we    : id_reg_we;
   assign new_in_delay  = sel_skid ? skid_in_delay  : id_in_delay;
   assign new_link_addr = sel_skid ? skid_link_addr : id_link_addr;

   pipe_slot #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W)
   ) u_main (
      .clk(clk), .rst(rst), .clr(main_clr), .load(main_load),
      .new_alusel(new_alusel), .new_aluop(new_aluop),
      .new_reg1_data(new_reg1_data), .new_reg2_data(new_reg2_data),
      .new_waddr(new_waddr), .new_reg_we(new_reg_we),
      .new_in_delay(new_in_delay), .new_link_addr(new_link_addr),
      .alusel(main_alusel), .aluop(main_aluop),
      .reg1_data(main_reg1_data), .reg2_data(main_reg2_data),
      .waddr(main_waddr), .reg_we(main_reg_we),
      .in_delay(main_in_delay), .link_addr(main_link_addr)
   );

   generate
      if (SKID_EN != 0) begin : g_skid
         logic skid_load;
         logic skid_clr;

         assign skid_load = accept & (state == ST_ONE) & ~consume;
         assign skid_clr  = flush | (sel_skid & consume);

         pipe_slot #(
            .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W)
         ) u_skid (
            .clk(clk), .rst(rst), .clr(skid_clr), .load(skid_load),
            .new_alusel(id_alusel), .new_aluop(id_aluop),
            .new_reg1_data(id_reg1_data), .new_reg2_data(id_reg2_data),
            .new_waddr(id_waddr), .new_reg_we(id_reg_we),
            .new_in_delay(id_in_delay), .new_link_addr(id_link_addr),
            .alusel(skid_alusel), .aluop(skid_aluop),
            .reg1_data(skid_reg1_data), .reg2_data(skid_reg2_data),
            .waddr(skid_waddr), .reg_we(skid_reg_we),
            .in_delay(skid_in_delay), .link_addr(skid_link_addr)
         );
      end else begin : g_no_skid
         assign skid_alusel    = ALUSEL_W'(EXE_RES_NOP);
         assign skid_aluop     = ALUOP_W'(EXE_NOP_OP);
         assign skid_reg1_data = DATA_W'(ZeroWord);
         assign skid_reg2_data = DATA_W'(ZeroWord);
         assign skid_waddr     = ADDR_W'(NOPRegAddr);
         assign skid_reg_we    = 1'b0;
         assign skid_in_delay  = 1'b0;
         assign skid_link_addr = DATA_W'(ZeroWord);
      end
   endgenerate

   // Bubbles always present NOP encodings downstream.
   assign ex_alusel    = ex_valid ? main_alusel    : ALUSEL_W'(EXE_RES_NOP);
   assign ex_aluop     = ex_valid ? main_aluop     : ALUOP_W'(EXE_NOP_OP);
   assign ex_reg1_data = ex_valid ? main_reg1_data : DATA_W'(ZeroWord);
   assign ex_reg2_data = ex_valid ? main_reg2_data : DATA_W'(ZeroWord);
   assign ex_waddr     = ex_valid ? main_waddr     : ADDR_W'(NOPRegAddr);
   assign ex_reg_we    = ex_valid & main_reg_we;
   assign ex_in_delay  = ex_valid & main_in_delay;
   assign ex_link_addr = ex_valid ? main_link_addr : DATA_W'(ZeroWord);

endmodule

`default_nettype wire

// File: tb/tb_id_ex_pipe.sv
// ============================================================================
// tb_id_ex_pipe : queue-model bench for id_ex_pipe, SKID_EN=1 and SKID_EN=0 builds
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_id_ex_pipe;

   typedef struct packed {
      logic [2:0]  alusel;
      logic [7:0]  aluop;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [4:0]  waddr;
      logic        we;
      logic        dly;
      logic [31:0] link;
   } op_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   logic id_valid = 1'b0;
   logic ex_ready = 1'b1;
   op_t  in_op = '0;
   logic chk_en = 1'b0;

   int n_chk = 0;
   int n_pass = 0;

   // Index 1: SKID_EN=1 build, index 0: SKID_EN=0 build.
   logic [2:0]  dut_alusel [2];
   logic [7:0]  dut_aluop  [2];
   logic [31:0] dut_r1     [2];
   logic [31:0] dut_r2     [2];
   logic [31:0] dut_link   [2];
   logic [4:0]  dut_waddr  [2];
   logic        dut_we     [2];
   logic        dut_dly    [2];
   logic        dut_valid  [2];
   logic        dut_ready  [2];
   logic [1:0]  dut_occ    [2];

   op_t q1[$];
   op_t q0[$];

   always #5 clk = ~clk;

   id_ex_pipe #(.SKID_EN(1)) u_dut_skid (
      .clk(clk), .rst(rst), .flush(flush),
      .id_valid(id_valid), .id_ready(dut_ready[1]),
      .id_alusel(in_op.alusel), .id_aluop(in_op.aluop),
      .id_reg1_data(in_op.r1), .id_reg2_data(in_op.r2),
      .id_waddr(in_op.waddr), .id_reg_we(in_op.we),
      .id_in_delay(in_op.dly), .id_link_addr(in_op.link),
      .ex_valid(dut_valid[1]), .ex_ready(ex_ready),
      .ex_alusel(dut_alusel[1]), .ex_aluop(dut_aluop[1]),
      .ex_reg1_data(dut_r1[1]), .ex_reg2_data(dut_r2[1]),
      .ex_waddr(dut_waddr[1]), .ex_reg_we(dut_we[1]),
      .ex_in_delay(dut_dly[1]), .ex_link_addr(dut_link[1]),
      .occupancy(dut_occ[1])
   );

   id_ex_pipe #(.SKID_EN(0)) u_dut_noskid (
      .clk(clk), .rst(rst), .flush(flush),
      .id_valid(id_valid), .id_ready(dut_ready[0]),
      .id_alusel(in_op.alusel), .id_aluop(in_op.aluop),
      .id_reg1_data(in_op.r1), .id_reg2_data(in_op.r2),
      .id_waddr(in_op.waddr), .id_reg_we(in_op.we),
      .id_in_delay(in_op.dly), .id_link_addr(in_op.link),
      .ex_valid(dut_valid[0]), .ex_ready(ex_ready),
      .ex_alusel(dut_alusel[0]), .ex_aluop(dut_aluop[0]),
      .ex_reg1_data(dut_r1[0]), .ex_reg2_data(dut_r2[0]),
      .ex_waddr(dut_waddr[0]), .ex_reg_we(dut_we[0]),
      .ex_in_delay(dut_dly[0]), .ex_link_addr(dut_link[0]),
      .occupancy(dut_occ[0])
   );

   function automatic op_t mk(input int s);
      op_t o;
      o.alusel = 3'(s);
      o.aluop  = 8'(s * 5 + 1);
      o.r1     = 32'h1111_0000 + 32'(s);
      o.r2     = ~o.r1;
      o.waddr  = 5'(s);
      o.we     = 1'b1;
      o.dly    = s[0];
      o.link   = 32'h0040_0000 + 32'(s * 4);
      return o;
   endfunction

   function automatic op_t act_op(input int k);
      return {dut_alusel[k], dut_aluop[k], dut_r1[k], dut_r2[k],
              dut_waddr[k], dut_we[k], dut_dly[k], dut_link[k]};
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      else n_pass++;
   endtask

   task automatic cmp_dut(input int k, input int sz, input op_t front);
      string tag;
      logic  exp_rdy;
      tag     = (k == 1) ? "skid" : "noskid";
      exp_rdy = (k == 1) ? (sz < 2) : (sz == 0 || ex_ready);
      chk({tag, "_valid"},   dut_valid[k], sz > 0);
      chk({tag, "_ready"},   dut_ready[k], exp_rdy);
      chk({tag, "_occ"},     dut_occ[k],   sz);
      chk({tag, "_payload"}, act_op(k),    (sz > 0) ? front : op_t'('0));
   endtask

   // Reference: a FIFO of capacity 2 (skid) or 1 (no skid); front is what EX sees.
   always @(posedge clk) begin
      bit a1, c1, a0, c0;
      if (rst || flush) begin
         q1.delete();
         q0.delete();
      end else begin
         a1 = id_valid && (q1.size() < 2);
         c1 = (q1.size() > 0) && ex_ready;
         a0 = id_valid && (q0.size() == 0 || ex_ready);
         c0 = (q0.size() > 0) && ex_ready;
         if (c1) void'(q1.pop_front());
         if (a1) q1.push_back(in_op);
         if (c0) void'(q0.pop_front());
         if (a0) q0.push_back(in_op);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         cmp_dut(1, q1.size(), (q1.size() > 0) ? q1[0] : op_t'('0));
         cmp_dut(0, q0.size(), (q0.size() > 0) ? q0[0] : op_t'('0));
      end
   end

   task automatic drive(input bit v, input int seed, input bit er, input bit fl);
      @(posedge clk);
      #1;
      id_valid = v;
      in_op    = mk(seed);
      ex_ready = er;
      flush    = fl;
   endtask

   initial begin
      @(posedge clk);
      #1 chk_en = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", dut_valid[1], 0);
      chk("rst_we",    dut_we[1],    0);
      chk("rst_waddr", dut_waddr[1], 0);
      chk("rst_occ",   dut_occ[1],   0);
      chk("rst_ready", dut_ready[1], 1);

      for (int i = 1; i <= 8; i++) begin
         drive(1, i, 1, 0);
         @(negedge clk);
         if (i > 1) begin
            chk("stream_waddr", dut_waddr[1], i - 1);
            chk("stream_valid", dut_valid[1], 1);
         end
      end
      drive(0, 0, 1, 0);
      @(negedge clk);
      chk("stream_last", dut_waddr[1], 8);

      drive(1, 3, 1, 0);
      drive(1, 4, 0, 0);
      @(negedge clk);
      chk("bp_a_waddr",      dut_waddr[1], 3);
      chk("bp_noskid_ready", dut_ready[0], 0);
      drive(0, 0, 0, 0);
      @(negedge clk);
      chk("bp_occ2",        dut_occ[1],   2);
      chk("bp_ready0",      dut_ready[1], 0);
      chk("bp_hold",        dut_waddr[1], 3);
      chk("bp_noskid_hold", dut_waddr[0], 3);
      drive(0, 0, 1, 0);
      @(negedge clk);
      chk("bp_drain_a", dut_waddr[1], 3);
      drive(0, 0, 1, 0);
      @(negedge clk);
      chk("bp_drain_b", dut_waddr[1], 4);
      chk("bp_occ1",    dut_occ[1],   1);
      drive(0, 0, 1, 0);
      @(negedge clk);
      chk("bp_occ0", dut_occ[1], 0);

      drive(1, 5, 0, 0);
      drive(1, 6, 0, 0);
      drive(1, 9, 1, 1);
      @(negedge clk);
      chk("fl_full",         dut_occ[1],   2);
      chk("fl_noskid_ready", dut_ready[0], 1);
      drive(0, 0, 0, 0);
      @(negedge clk);
      chk("fl_valid",        dut_valid[1], 0);
      chk("fl_occ",          dut_occ[1],   0);
      chk("fl_noskid_valid", dut_valid[0], 0);
      drive(0, 0, 1, 0);
      @(negedge clk);
      chk("fl_no9", dut_valid[1], 0);

      drive(0, 7, 1, 0);
      drive(0, 7, 1, 0);
      @(negedge clk);
      chk("bub_we",        dut_we[1],    0);
      chk("bub_waddr",     dut_waddr[1], 0);
      chk("bub_noskid_we", dut_we[0],    0);

      drive(1, 10, 0, 0);
      drive(1, 11, 0, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      in_op = mk(12);
      @(negedge clk);
      chk("mid_full", dut_occ[1], 2);
      @(posedge clk);
      #1 rst = 1'b0;
      id_valid = 1'b0;
      ex_ready = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", dut_valid[1], 0);
      chk("mid_rst_ready", dut_ready[1], 1);

      for (int i = 0; i < 60; i++) begin
         drive(1'($urandom_range(0, 1)), 16 + i, 1'($urandom_range(0, 1)),
               $urandom_range(0, 15) == 0);
      end
      drive(0, 0, 1, 0);
      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
